i2c_target_rx: RTL and testbench

//  I2C target (slave) receiver: the responder end of the i2c_tx initiator link.

---
 rtl/i2c_target_rx_pkg.sv | 27 ++
 rtl/i2c_target_rx_bus_sync.sv | 38 +++
 rtl/i2c_target_rx.sv | 142 ++++++++++++++
 tb/tb_i2c_target_rx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_rx_pkg.sv
// Shared types and constants for the I2C target receiver.
package i2c_target_rx_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;
  localparam int unsigned ADDR_W    = 7;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  localparam logic [ADDR_W-1:0] I2C_DEFAULT_ADDR = 7'h20;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_DATA     = 3'd3,
    ST_DATA_ACK = 3'd4,
    ST_IGNORE   = 3'd5
  } state_e;

  // Width of the frame byte index; at least one bit even for single-byte frames.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/i2c_target_rx_bus_sync.sv
// Synchronizes SCL/SDA into clk and decodes edge and START/STOP pulses.
module i2c_target_rx_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_c,
  output logic scl_rise_c,
  output logic scl_fall_c,
  output logic start_c,
  output logic stop_c
);

  // [0],[1] are the synchronizer; [2] is the history stage for edge detection.
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  // Shift pads through the synchronizer chain; idle bus level after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end

  // SDA edges while SCL is held high are bus conditions, not data.
  always_comb begin
    sda_c      = sda_q[1];
    scl_rise_c = scl_q[1] & ~scl_q[2];
    scl_fall_c = ~scl_q[1] & scl_q[2];
    start_c    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    stop_c     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
  end

endmodule

// File: rtl/i2c_target_rx.sv
// I2C write-only target: address match, ACK generation and indexed byte output.
module i2c_target_rx
  import i2c_target_rx_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR  = I2C_DEFAULT_ADDR,
  parameter int unsigned       BYTES = 2,
  localparam int unsigned      IW    = idx_width(BYTES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic [BYTE_W-1:0] data_out,
  output logic [IW-1:0]     index_out,
  output logic              wr_en,
  output logic              busy
);

  logic sda_c, scl_rise_c, scl_fall_c, start_c, stop_c;

  i2c_target_rx_bus_sync u_bus_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .sda_c      (sda_c),
    .scl_rise_c (scl_rise_c),
    .scl_fall_c (scl_fall_c),
    .start_c    (start_c),
    .stop_c     (stop_c)
  );

  state_e                state_q, state_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  done_q, done_d;
  logic [BYTE_W-1:0]     shift_q, shift_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  sda_oe_d, wr_en_d, busy_d;
  logic [BYTE_W-1:0]     data_d;
  logic [IW-1:0]         index_d;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
      shift_q   <= '0;
      idx_q     <= '0;
      sda_oe    <= 1'b0;
      wr_en     <= 1'b0;
      busy      <= 1'b0;
      data_out  <= '0;
      index_out <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      done_q    <= done_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      sda_oe    <= sda_oe_d;
      wr_en     <= wr_en_d;
      busy      <= busy_d;
      data_out  <= data_d;
      index_out <= index_d;
    end
  end

  // Next state and outputs; STOP outranks START, both outrank the byte FSM.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = done_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    sda_oe_d  = sda_oe;
    wr_en_d   = 1'b0;
    busy_d    = busy;
    data_d    = data_out;
    index_d   = index_out;

    if (stop_c) begin
      state_d   = ST_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
      done_d    = 1'b0;
    end else if (start_c) begin
      state_d   = ST_ADDR;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_DATA: begin
          if (scl_rise_c && !done_q) begin
            shift_d   = {shift_q[BYTE_W-2:0], sda_c};
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1)) done_d = 1'b1;
          end else if (scl_fall_c && done_q) begin
            done_d    = 1'b0;
            bit_cnt_d = '0;
            if (state_q == ST_ADDR) begin
              if (shift_q == {ADDR, I2C_RW_WRITE}) begin
                state_d  = ST_ADDR_ACK;
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                idx_d    = '0;
              end else begin
                state_d  = ST_IGNORE;
              end
            end else begin
              state_d  = ST_DATA_ACK;
              sda_oe_d = 1'b1;
              wr_en_d  = 1'b1;
              data_d   = shift_q;
              index_d  = idx_q;
              idx_d    = (idx_q == IW'(BYTES - 1)) ? '0 : idx_q + IW'(1);
            end
          end
        end
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (scl_fall_c) begin
            state_d  = ST_DATA;
            sda_oe_d = 1'b0;
          end
        end
        ST_IGNORE, ST_IDLE: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: bus-level master model plus byte scoreboard.
`timescale 1ns/1ps
module tb_i2c_target_rx;

  localparam int unsigned Q = 10;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       sda_m;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] data_out;
  logic [0:0] index_out;
  logic       wr_en;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int oe_cycles = 0;
  int busy_cycles = 0;
  logic [15:0] sb_q[$];

  assign sda_line = sda_m & ~sda_oe;

  i2c_target_rx #(.ADDR(7'h20), .BYTES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .data_out  (data_out),
    .index_out (index_out),
    .wr_en     (wr_en),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every write strobe.
  always @(negedge clk) begin
    logic [15:0] e;
    if (sda_oe === 1'b1) oe_cycles++;
    if (busy === 1'b1) busy_cycles++;
    if (wr_en === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("wr_en_unexpected", 32'(wr_en), 32'(0));
      end else begin
        e = sb_q.pop_front();
        check("data_out", 32'(data_out), 32'(e[7:0]));
        check("index_out", 32'(index_out), 32'(e[15:8]));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_q(input int n = 1);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_q();
    scl   = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl   = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_q();
    scl   = 1'b1; wait_q();
    sda_m = 1'b1; wait_q(2);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wait_q();
    scl   = 1'b1; wait_q(2);
    scl   = 1'b0; wait_q();
  endtask

  task automatic get_ack(output logic ack);
    sda_m = 1'b1; wait_q();
    scl   = 1'b1; wait_q();
    ack   = ~sda_line; wait_q();
    scl   = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    logic ack;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    get_ack(ack);
    check(tag, 32'(ack), 32'(exp_ack));
  endtask

  task automatic send_data(input logic [7:0] b, input logic [7:0] idx);
    sb_q.push_back({idx, b});
    send_byte(b, 1'b1, "data_ack");
  endtask

  initial begin
    int oe0, busy0;
    rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_data_out", 32'(data_out), 0);
    check("rst_index_out", 32'(index_out), 0);

    // Two-byte write to our address.
    bus_start();
    send_byte(8'h40, 1'b1, "addr_ack");
    check("busy_addressed", 32'(busy), 1);
    send_data(8'hA5, 8'd0);
    send_data(8'h3C, 8'd1);
    bus_stop();
    check("busy_after_stop", 32'(busy), 0);

    // Wrong address: never driven, never busy.
    oe0 = oe_cycles; busy0 = busy_cycles;
    bus_start();
    send_byte(8'h42, 1'b0, "wrong_addr_nack");
    send_byte(8'hFF, 1'b0, "wrong_addr_data_nack");
    bus_stop();
    check("wrong_addr_oe_cycles", 32'(oe_cycles - oe0), 0);
    check("wrong_addr_busy_cycles", 32'(busy_cycles - busy0), 0);

    // Read request is refused, then a write is accepted.
    bus_start();
    send_byte(8'h41, 1'b0, "read_nack");
    send_byte(8'h5A, 1'b0, "ignore_nack");
    bus_stop();
    bus_start();
    send_byte(8'h40, 1'b1, "addr_ack2");
    send_data(8'h11, 8'd0);
    bus_stop();

    // Index wraps every two bytes.
    bus_start();
    send_byte(8'h40, 1'b1, "addr_ack3");
    for (int i = 1; i <= 5; i++) send_data(8'(i), 8'((i - 1) % 2));
    bus_stop();

    // STOP in the middle of a byte discards it.
    bus_start();
    send_byte(8'h40, 1'b1, "addr_ack4");
    send_data(8'h77, 8'd0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus_stop();
    check("partial_sda_oe", 32'(sda_oe), 0);
    check("partial_busy", 32'(busy), 0);
    bus_start();
    send_byte(8'h40, 1'b1, "addr_ack5");
    send_data(8'h99, 8'd0);
    bus_stop();

    // Reset pulse during the address ACK.
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 6);
    sda_m = 1'b1; wait_q();
    scl = 1'b1; wait_q();
    check("ack_before_rst", 32'(sda_oe), 1);
    check("busy_before_rst", 32'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_sda_oe", 32'(sda_oe), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_data_out", 32'(data_out), 0);
    check("midrst_index_out", 32'(index_out), 0);
    check("midrst_wr_en", 32'(wr_en), 0);
    oe0 = oe_cycles;
    wait_q();
    scl = 1'b0; wait_q();
    send_byte(8'h55, 1'b0, "post_rst_nack");
    bus_stop();
    check("post_rst_oe_cycles", 32'(oe_cycles - oe0), 0);

    repeat (10) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
